// File: rtl/interval_timer_arbiter.sv
// Shared interval counter: a round-robin arbiter hands one N-bit counter to one of
// NREQ requesters, counts len+1 qualifying ticks, then pulses done to the owner.
module interval_timer_arbiter #(
  parameter int NREQ = 4,
  parameter int N    = 7
) (
  input  logic              clk,
  input  logic              asyncReset_n,
  input  logic              tick,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] len,
  input  logic              cancel,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic [N-1:0]      count,
  output logic [NREQ-1:0]   done,
  output logic              aborted
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_RELEASE
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic            aborted_q, aborted_d;
  logic [N-1:0]    count_q, count_d;
  logic [N-1:0]    lim_q, lim_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;

  logic [IW-1:0]   winner;
  logic            found;
  int              idx;

  // Round-robin pick: first set req bit at or above ptr_q, wrapping to 0.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[IW'(idx)]) begin
        winner = IW'(idx);
        found  = 1'b1;
      end
    end
  end

  // NOTE: every variable gets its hold value first so no path through the
  // case statement leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    done_d    = done_q;
    busy_d    = busy_q;
    aborted_d = aborted_q;
    count_d   = count_q;
    lim_d     = lim_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          owner_d = winner;
          grant_d = NREQ'(1) << winner;
          busy_d  = 1'b1;
          count_d = '0;
          lim_d   = len[int'(winner)*N +: N];
          state_d = S_COUNT;
        end
      end

      S_COUNT: begin
        // Abort outranks completion, so cancel on the terminal tick yields aborted.
        if (cancel || !req[owner_q]) begin
          aborted_d = 1'b1;
          state_d   = S_RELEASE;
        end else if (tick && (count_q == lim_q)) begin
          done_d  = NREQ'(1) << owner_q;
          state_d = S_RELEASE;
        end else if (tick) begin
          count_d = count_q + 1'b1;
        end
      end

      S_RELEASE: begin
        grant_d   = '0;
        busy_d    = 1'b0;
        done_d    = '0;
        aborted_d = 1'b0;
        count_d   = '0;
        ptr_d     = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge asyncReset_n) begin
    if (!asyncReset_n) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      aborted_q <= 1'b0;
      count_q   <= '0;
      lim_q     <= '0;
      ptr_q     <= '0;
      owner_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      aborted_q <= aborted_d;
      count_q   <= count_d;
      lim_q     <= lim_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign count   = count_q;
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Self-checking bench for interval_timer_arbiter: stimulus tables, directed corner
// sequences and randomized traffic, all compared against a transaction-level model.
module tb_interval_timer_arbiter;

  localparam int NREQ = 4;
  localparam int N    = 7;

  logic              clk = 1'b0;
  logic              asyncReset_n;
  logic              tick;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] len;
  logic              cancel;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic [N-1:0]      count;
  logic [NREQ-1:0]   done;
  logic              aborted;

  interval_timer_arbiter #(.NREQ(NREQ), .N(N)) dut (
    .clk          (clk),
    .asyncReset_n (asyncReset_n),
    .tick         (tick),
    .req          (req),
    .len          (len),
    .cancel       (cancel),
    .grant        (grant),
    .busy         (busy),
    .count        (count),
    .done         (done),
    .aborted      (aborted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the counter, how many ticks it has absorbed,
  // and whether the interval has just ended (one visible release cycle).
  int m_owner;     // -1 when nobody owns the counter
  int m_ticks;     // ticks absorbed so far, shown on count
  int m_target;    // interval length in ticks (len + 1)
  int m_next;      // requester with first claim at the next arbitration
  int m_done_to;   // requester being told done, -1 if none
  bit m_ending;
  bit m_aborted;

  function automatic void model_reset();
    m_owner   = -1;
    m_ticks   = 0;
    m_target  = 1;
    m_next    = 0;
    m_done_to = -1;
    m_ending  = 1'b0;
    m_aborted = 1'b0;
  endfunction

  function automatic void model_step();
    if (m_ending) begin
      m_next    = (m_owner + 1) % NREQ;
      m_owner   = -1;
      m_ticks   = 0;
      m_done_to = -1;
      m_aborted = 1'b0;
      m_ending  = 1'b0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_next + k) % NREQ;
        if (m_owner < 0 && req[i]) begin
          m_owner  = i;
          m_ticks  = 0;
          m_target = int'(len[i*N +: N]) + 1;
        end
      end
    end else if (cancel || !req[m_owner]) begin
      m_aborted = 1'b1;
      m_ending  = 1'b1;
    end else if (tick) begin
      if (m_ticks + 1 == m_target) begin
        m_done_to = m_owner;
        m_ending  = 1'b1;
      end else begin
        m_ticks++;
      end
    end
  endfunction

  task automatic compare_model();
    logic [NREQ-1:0] eg, ed;
    eg = (m_owner >= 0) ? NREQ'(1) << m_owner : '0;
    ed = (m_done_to >= 0) ? NREQ'(1) << m_done_to : '0;
    check("mdl_grant",   grant,   eg);
    check("mdl_busy",    busy,    m_owner >= 0);
    check("mdl_count",   count,   m_ticks);
    check("mdl_done",    done,    ed);
    check("mdl_aborted", aborted, m_aborted);
    check("inv_excl",    (done != 0) && aborted, 0);
    check("inv_onehot0", $onehot0(grant), 1);
  endtask

  task automatic step(input logic [NREQ-1:0] r, input logic t, input logic c);
    req    = r;
    tick   = t;
    cancel = c;
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    asyncReset_n = 1'b0;
    req    = '0;
    tick   = 1'b0;
    cancel = 1'b0;
    len    = '0;
    model_reset();
    repeat (2) @(negedge clk);
    asyncReset_n = 1'b1;
  endtask

  typedef struct {
    logic [NREQ-1:0] req;
    logic            tick;
    logic            cancel;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] done;
    logic            busy;
    logic [N-1:0]    count;
    logic            aborted;
  } vec_t;

  vec_t single_vecs[$];
  vec_t rr_vecs[$];

  task automatic run_table(input string tag, input vec_t v[$]);
    foreach (v[i]) begin
      step(v[i].req, v[i].tick, v[i].cancel);
      check({tag, "_grant"},   grant,   v[i].grant);
      check({tag, "_done"},    done,    v[i].done);
      check({tag, "_busy"},    busy,    v[i].busy);
      check({tag, "_count"},   count,   v[i].count);
      check({tag, "_aborted"}, aborted, v[i].aborted);
    end
  endtask

  initial begin
    int ticks;
    bit saw_max;
    logic [NREQ-1:0] r;

    // Single request, len[1]=3, tick held: grant, 4 ticks, done, release.
    single_vecs = '{
      '{4'b0010, 1'b1, 1'b0, 4'b0010, 4'b0000, 1'b1, 7'd0, 1'b0},
      '{4'b0010, 1'b1, 1'b0, 4'b0010, 4'b0000, 1'b1, 7'd1, 1'b0},
      '{4'b0010, 1'b1, 1'b0, 4'b0010, 4'b0000, 1'b1, 7'd2, 1'b0},
      '{4'b0010, 1'b1, 1'b0, 4'b0010, 4'b0000, 1'b1, 7'd3, 1'b0},
      '{4'b0010, 1'b1, 1'b0, 4'b0010, 4'b0010, 1'b1, 7'd3, 1'b0},
      '{4'b0010, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 7'd0, 1'b0},
      '{4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 7'd0, 1'b0}
    };
    // Round robin with all len=0: grant, done on first tick, idle gap; order 0,1,2,3,0.
    for (int g = 0; g < 5; g++) begin
      logic [NREQ-1:0] oh;
      oh = NREQ'(1) << (g % NREQ);
      rr_vecs.push_back('{4'b1111, 1'b1, 1'b0, oh,      4'b0000, 1'b1, 7'd0, 1'b0});
      rr_vecs.push_back('{4'b1111, 1'b1, 1'b0, oh,      oh,      1'b1, 7'd0, 1'b0});
      rr_vecs.push_back('{4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 7'd0, 1'b0});
    end

    do_reset();
    #1;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);

    len[1*N +: N] = 7'd3;
    run_table("single", single_vecs);

    do_reset();
    run_table("rr", rr_vecs);

    // Slow ticks: every third cycle, len[2]=2 -> done after exactly 3 ticks.
    do_reset();
    len[2*N +: N] = 7'd2;
    step(4'b0100, 1'b0, 1'b0);
    ticks = 0;
    for (int c = 0; c < 30; c++) begin
      logic t;
      t = (c % 3 == 2);
      step(4'b0100, t, 1'b0);
      if (t) ticks++;
      if (done != 0) break;
    end
    check("slow_done", done, 4'b0100);
    check("slow_ticks", ticks, 3);
    check("slow_count", count, 2);
    step(4'b0000, 1'b0, 1'b0);

    // Cancel at count=5 with len[0]=10.
    do_reset();
    len[0*N +: N] = 7'd10;
    step(4'b0001, 1'b0, 1'b0);
    repeat (5) step(4'b0001, 1'b1, 1'b0);
    check("abort_count5", count, 5);
    step(4'b0001, 1'b1, 1'b1);
    check("abort_pulse", aborted, 1);
    check("abort_nodone", done, 0);
    check("abort_grant_held", grant, 4'b0001);
    step(4'b0001, 1'b0, 1'b0);
    check("abort_released", grant, 0);
    check("abort_pulse_end", aborted, 0);
    step(4'b0000, 1'b0, 1'b0);

    // Cancel on the terminal tick gives aborted, never done.
    do_reset();
    len[0*N +: N] = 7'd2;
    step(4'b0001, 1'b0, 1'b0);
    repeat (2) step(4'b0001, 1'b1, 1'b0);
    check("term_count", count, 2);
    step(4'b0001, 1'b1, 1'b1);
    check("term_aborted", aborted, 1);
    check("term_nodone", done, 0);
    step(4'b0000, 1'b0, 1'b0);

    // Requester drops req mid-count.
    do_reset();
    len[0*N +: N] = 7'd10;
    step(4'b0001, 1'b0, 1'b0);
    repeat (3) step(4'b0001, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    check("drop_aborted", aborted, 1);
    check("drop_nodone", done, 0);
    step(4'b0000, 1'b0, 1'b0);
    check("drop_released", busy, 0);

    // Full width: len=127 reaches all-ones without wrapping, done after 128 ticks.
    do_reset();
    len[3*N +: N] = 7'd127;
    step(4'b1000, 1'b0, 1'b0);
    ticks   = 0;
    saw_max = 1'b0;
    for (int c = 0; c < 200; c++) begin
      step(4'b1000, 1'b1, 1'b0);
      ticks++;
      if (count == 7'd127) saw_max = 1'b1;
      if (done != 0) break;
    end
    check("full_done", done, 4'b1000);
    check("full_ticks", ticks, 128);
    check("full_count", count, 127);
    check("full_saw_max", saw_max, 1);
    step(4'b0000, 1'b0, 1'b0);

    // Asynchronous reset between edges mid-count clears outputs at once.
    do_reset();
    len[0*N +: N] = 7'd10;
    step(4'b0001, 1'b0, 1'b0);
    repeat (3) step(4'b0001, 1'b1, 1'b0);
    check("pre_rst_count", count, 3);
    #2;
    asyncReset_n = 1'b0;
    #1;
    check("mid_rst_grant", grant, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_aborted", aborted, 0);
    model_reset();
    @(negedge clk);
    asyncReset_n = 1'b1;
    repeat (3) step(4'b0000, 1'b1, 1'b0);

    // Randomized traffic, len changing every cycle to exercise the IDLE latch.
    do_reset();
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) len[i*N +: N] = 7'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) r = NREQ'($urandom);
      step(r, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
